// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// A zero divisor takes a one-cycle bypass and returns all-ones quotient with the dividend as remainder.
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ZERO,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] d_d;
    logic             last_d;

    // The partial remainder always stays below the divisor, so WIDTH bits hold it
    // between steps; only the shifted trial value needs the extra borrow bit.
    always_comb begin
        shift_d = {p_q, d_q[WIDTH-1]};
        trial_d = shift_d - {1'b0, dvs_q};
        p_d     = trial_d[WIDTH] ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
        d_d     = {d_q[WIDTH-2:0], ~trial_d[WIDTH]};
        last_d  = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            d_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        dvs_q <= divisor;
                        d_q   <= dividend;
                        p_q   <= '0;
                        cnt_q <= '0;
                        if (divisor != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_ZERO;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    p_q   <= p_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= d_d;
                        rem_q   <= p_d;
                        dbz_q   <= 1'b0;
                    end
                end
                S_ZERO: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    quo_q   <= '1;
                    rem_q   <= d_q;
                    dbz_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
